ahb_simple_master: RTL and testbench

AHB_SIMPLE_MASTER -- requirements
Module: ahb_simple_master

---
 rtl/ahb_simple_master_if.sv | 40 ++++
 rtl/ahb_simple_master.sv | 166 ++++++++++++++++
 tb/tb_ahb_simple_master.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_simple_master_if.sv
// Command, write-data, response and AHB bus signals of ahb_simple_master.
// master = the design's view, slave = the environment (command source + AHB slave).
interface ahb_simple_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [4:0]            cmd_len;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wdata_pop;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;
  logic                  rsp_last;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic [1:0]            HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, HRDATA, HREADY, HRESP,
    output cmd_ready, wdata_pop, rsp_valid, rsp_rdata, rsp_error, rsp_last,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, HRDATA, HREADY, HRESP,
    input  cmd_ready, wdata_pop, rsp_valid, rsp_rdata, rsp_error, rsp_last,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
  );
endinterface

// File: rtl/ahb_simple_master.sv
// Single-command AHB-Lite master: turns one read/write command of 1..16 word beats into a
// pipelined INCR/SINGLE transfer and reports one response per completed data phase.
module ahb_simple_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                HCLK,
  input  logic                HRESET,
  ahb_simple_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, ADDR, BURST, ERR} state_e;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [4:0]            len_q, len_d;
  logic [4:0]            beat_q, beat_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic                  wpop_q, wpop_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_last_q, rsp_last_d;
  logic                  resp_err;
  logic                  more;
  logic [1:0]            htrans;

  // beat_q counts accepted address phases, so in BURST the data phase is the last one
  // exactly when every address has already gone out.
  assign resp_err = (bus.HRESP != RESP_OKAY);
  assign more     = (beat_q != len_q);

  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.cmd_valid) state_d = ADDR;
      ADDR:  if (bus.HREADY) state_d = BURST;
      BURST: begin
        if (resp_err)                    state_d = bus.HREADY ? IDLE : ERR;
        else if (bus.HREADY && !more)    state_d = IDLE;
      end
      ERR:   if (bus.HREADY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    write_d     = write_q;
    hwdata_d    = hwdata_q;
    wpop_d      = 1'b0;
    rsp_vld_d   = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    rsp_last_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr & ~ADDR_WIDTH'(3);
          len_d   = (bus.cmd_len == 5'd0) ? 5'd1 : bus.cmd_len;
          beat_d  = 5'd0;
          write_d = bus.cmd_write;
        end
      end
      ADDR: begin
        if (bus.HREADY) begin
          addr_d   = addr_q + ADDR_WIDTH'(4);
          beat_d   = 5'd1;
          hwdata_d = write_q ? bus.wdata : hwdata_q;
          wpop_d   = write_q;
        end
      end
      BURST: begin
        if (resp_err) begin
          if (bus.HREADY) begin
            rsp_vld_d  = 1'b1;
            rsp_err_d  = 1'b1;
            rsp_last_d = 1'b1;
          end
        end else if (bus.HREADY) begin
          rsp_vld_d   = 1'b1;
          rsp_rdata_d = write_q ? '0 : bus.HRDATA;
          rsp_last_d  = !more;
          if (more) begin
            addr_d   = addr_q + ADDR_WIDTH'(4);
            beat_d   = beat_q + 5'd1;
            hwdata_d = write_q ? bus.wdata : hwdata_q;
            wpop_d   = write_q;
          end
        end
      end
      ERR: begin
        if (bus.HREADY) begin
          rsp_vld_d  = 1'b1;
          rsp_err_d  = 1'b1;
          rsp_last_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q      <= '0;
      len_q       <= 5'd1;
      beat_q      <= 5'd0;
      write_q     <= 1'b0;
      hwdata_q    <= '0;
      wpop_q      <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      write_q     <= write_d;
      hwdata_q    <= hwdata_d;
      wpop_q      <= wpop_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  // An error response cancels the overlapping address phase in the same cycle.
  always_comb begin
    htrans = TRANS_IDLE;
    unique case (state_q)
      ADDR:  htrans = TRANS_NONSEQ;
      BURST: if (more && !resp_err) htrans = (addr_q[9:0] == 10'd0) ? TRANS_NONSEQ : TRANS_SEQ;
      default: htrans = TRANS_IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE) && !HRESET;
  assign bus.HTRANS    = htrans;
  assign bus.HADDR     = addr_q;
  assign bus.HWRITE    = write_q;
  assign bus.HSIZE     = 3'b010;
  assign bus.HBURST    = (len_q == 5'd1) ? 3'b000 : 3'b001;
  assign bus.HPROT     = 4'b0011;
  assign bus.HWDATA    = hwdata_q;
  assign bus.wdata_pop = wpop_q;
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_err_q;
  assign bus.rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_ahb_simple_master.sv
// Table of commands run against a cycle-level AHB slave model; responses are
// scoreboarded when the slave completes a data phase and popped when rsp_valid shows.
module tb_ahb_simple_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  ahb_simple_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  ahb_simple_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [4:0]  len;
    int          wait_beat, wait_n;
    int          err_beat, err_mode;
    int          rst_beat;
    int          exp_rsp, exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        last;
    logic        chk_data;
  } rsp_t;

  rsp_t sb[$];
  int n_chk = 0, n_fail = 0, cyc = 0, rsp_seen = 0, rsp_cyc = -1;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return {16'hA5A5, a[15:0]} ^ 32'h0000_0101;
  endfunction

  function automatic logic [31:0] wd_pat(input int v, input int b);
    return 32'h5A00_0000 | 32'(v << 8) | 32'(b);
  endfunction

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [4:0] len,
                              input int wb, input int wn, input int eb, input int em,
                              input int rb, input int er, input int el);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.wait_beat = wb; v.wait_n = wn;
    v.err_beat = eb; v.err_mode = em; v.rst_beat = rb; v.exp_rsp = er; v.exp_lat = el;
    return v;
  endfunction

  // Response monitor: sampled well after the edge, compared against the scoreboard head.
  always @(posedge HCLK) begin
    #3;
    if (bus.rsp_valid === 1'b1) begin
      rsp_seen++;
      if (rsp_cyc < 0) rsp_cyc = cyc;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_error", bus.rsp_error, e.err);
        chk("rsp_last", bus.rsp_last, e.last);
        if (e.chk_data) chk("rsp_rdata", bus.rsp_rdata, e.rdata);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_HTRANS"}, bus.HTRANS, 32'd0);
    chk({tag, "_HADDR"}, bus.HADDR, 32'd0);
    chk({tag, "_HWRITE"}, bus.HWRITE, 32'd0);
    chk({tag, "_HSIZE"}, bus.HSIZE, 32'd2);
    chk({tag, "_HBURST"}, bus.HBURST, 32'd0);
    chk({tag, "_HPROT"}, bus.HPROT, 32'd3);
    chk({tag, "_HWDATA"}, bus.HWDATA, 32'd0);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 32'd0);
    chk({tag, "_wdata_pop"}, bus.wdata_pop, 32'd0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 32'd0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    chk({tag, "_rsp_error"}, bus.rsp_error, 32'd0);
    chk({tag, "_rsp_last"}, bus.rsp_last, 32'd0);
  endtask

  // Entered one time unit after a rising edge with the DUT idle; leaves the same way.
  task automatic run_vec(input int vi, input vec_t v);
    int eff_len, abeat, dp_beat, dp_cyc, waits, acc_cyc;
    logic [31:0] base, exp_a;
    logic [1:0] resp, exp_tr;
    logic rdy, final_now, done, err_now;
    rsp_t e;
    eff_len = (v.len == 5'd0) ? 1 : int'(v.len);
    base = v.addr & ~32'h3;
    rsp_seen = 0;
    rsp_cyc = -1;

    bus.cmd_valid = 1'b1; bus.cmd_write = v.wr; bus.cmd_addr = v.addr; bus.cmd_len = v.len;
    bus.wdata = wd_pat(vi, 0); bus.HREADY = 1'b1; bus.HRESP = 2'b00;
    #1;
    chk("cmd_ready_idle", bus.cmd_ready, 32'd1);
    acc_cyc = cyc;
    @(posedge HCLK); #1;

    abeat = 0; dp_beat = -1; dp_cyc = 0; done = 1'b0;
    for (int budget = 0; budget < 200 && !done; budget++) begin
      rdy = 1'b1; resp = 2'b00; err_now = 1'b0;
      if (dp_beat >= 0) begin
        if (dp_beat == v.err_beat) begin
          err_now = 1'b1;
          if (v.err_mode == 0) begin rdy = (dp_cyc > 0); resp = 2'b01; end
          else begin rdy = 1'b1; resp = 2'b10; end
        end else begin
          waits = (dp_beat == v.wait_beat) ? v.wait_n : 0;
          rdy = (dp_cyc >= waits);
        end
      end
      final_now = (dp_beat >= 0) && rdy && (err_now || dp_beat == eff_len - 1);
      exp_a = base + 32'(abeat * 4);
      exp_tr = (abeat < eff_len && !err_now) ?
               ((abeat == 0 || exp_a[9:0] == 10'd0) ? 2'b10 : 2'b11) : 2'b00;

      if (dp_beat >= 0 && dp_beat == v.rst_beat) begin
        HRESET = 1'b1; bus.cmd_valid = 1'b0; bus.HREADY = 1'b0; bus.HRESP = 2'b00;
        @(posedge HCLK); #1;
        check_reset_outputs("midrst");
        HRESET = 1'b0;
        done = 1'b1;
      end else begin
        bus.HREADY = rdy; bus.HRESP = resp;
        bus.HRDATA = (dp_beat >= 0) ? rd_pat(base + 32'(dp_beat * 4)) : 32'hDEAD_BEEF;
        bus.cmd_valid = !final_now; bus.cmd_addr = 32'h0BAD_0000;
        bus.cmd_write = ~v.wr; bus.cmd_len = 5'd3;
        bus.wdata = wd_pat(vi, abeat);
        #1;
        chk("HTRANS", bus.HTRANS, exp_tr);
        if (exp_tr != 2'b00) begin
          chk("HADDR", bus.HADDR, exp_a);
          chk("HWRITE", bus.HWRITE, v.wr);
          chk("HBURST", bus.HBURST, (eff_len == 1) ? 32'd0 : 32'd1);
        end
        if (dp_beat >= 0 && v.wr) chk("HWDATA", bus.HWDATA, wd_pat(vi, dp_beat));
        chk("wdata_pop", bus.wdata_pop, v.wr && dp_beat >= 0 && dp_cyc == 0);
        chk("cmd_ready_busy", bus.cmd_ready, 32'd0);
        if (dp_beat >= 0 && rdy) begin
          e.rdata = v.wr ? 32'd0 : rd_pat(base + 32'(dp_beat * 4));
          e.err = err_now; e.last = final_now; e.chk_data = !err_now;
          sb.push_back(e);
        end
        if (final_now) done = 1'b1;
        if (rdy) begin
          if (exp_tr != 2'b00) begin dp_beat = abeat; abeat++; end
          else dp_beat = -1;
          dp_cyc = 0;
        end else begin
          dp_cyc++;
        end
        @(posedge HCLK); #1;
      end
    end
    if (!done) chk("transfer_timeout", 32'd0, 32'd1);

    bus.cmd_valid = 1'b0; bus.HREADY = 1'b1; bus.HRESP = 2'b00;
    #1;
    chk("cmd_ready_after", bus.cmd_ready, 32'd1);
    chk("HTRANS_after", bus.HTRANS, 32'd0);
    @(posedge HCLK); #1;
    chk("rsp_count", rsp_seen, v.exp_rsp);
    chk("sb_empty", sb.size(), 32'd0);
    if (v.exp_lat > 0) chk("accept_to_rsp", rsp_cyc - acc_cyc - 1, v.exp_lat);
    sb.delete();
  endtask

  initial begin
    vec_t tbl[12];
    HRESET = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wdata = '0; bus.HRDATA = '0; bus.HREADY = 1'b1; bus.HRESP = 2'b00;

    //            wr    addr           len  wbeat wn ebeat emode rbeat rsp lat
    tbl[0]  = mk(1'b0, 32'h0000_0100, 5'd1,  -1, 0,  -1,  0,   -1,   1,  2);
    tbl[1]  = mk(1'b1, 32'h0000_0200, 5'd4,   1, 2,  -1,  0,   -1,   4,  0);
    tbl[2]  = mk(1'b0, 32'h0000_03F8, 5'd4,  -1, 0,  -1,  0,   -1,   4,  0);
    tbl[3]  = mk(1'b0, 32'h0000_0000, 5'd8,  -1, 0,   2,  0,   -1,   3,  0);
    tbl[4]  = mk(1'b1, 32'h0000_1000, 5'd0,  -1, 0,  -1,  0,   -1,   1,  0);
    tbl[5]  = mk(1'b0, 32'hFFFF_FFF8, 5'd4,  -1, 0,  -1,  0,   -1,   4,  0);
    tbl[6]  = mk(1'b1, 32'h0000_0040, 5'd16, 15, 1,  -1,  0,   -1,  16,  0);
    tbl[7]  = mk(1'b1, 32'h0000_0080, 5'd2,  -1, 0,   0,  0,   -1,   1,  0);
    tbl[8]  = mk(1'b0, 32'h0000_0103, 5'd2,   0, 3,  -1,  0,   -1,   2,  0);
    tbl[9]  = mk(1'b0, 32'h0000_0500, 5'd4,  -1, 0,   1,  1,   -1,   2,  0);
    tbl[10] = mk(1'b1, 32'h0000_0600, 5'd4,  -1, 0,  -1,  0,    1,   1,  0);
    tbl[11] = mk(1'b0, 32'h0000_0200, 5'd2,  -1, 0,  -1,  0,   -1,   2,  0);

    repeat (3) @(posedge HCLK);
    #1;
    check_reset_outputs("reset");
    HRESET = 1'b0;
    #1;
    chk("cmd_ready_release", bus.cmd_ready, 32'd1);
    @(posedge HCLK); #1;

    for (int i = 0; i < 12; i++) run_vec(i, tbl[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks made", n_chk);
    $fatal(1, "watchdog expired");
  end
endmodule
